i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//   I2C target (slave) with a small internal register file; the downstream consumer of i2c_master's scl/sda.
//   Decodes START/STOP, matches a 7-bit device address, ACKs, takes a register pointer, then services
//   auto-incrementing writes and reads. Oversamples the bus on the system clock; drives SDA open-drain only.
// PARAMETERS
//   DEV_ADDR   7'h55  7-bit device address matched against the first byte after START
//   NREGS      4      number of 8-bit registers (2..16); pointer wraps modulo NREGS
//   PTR_W      2      pointer width, = clog2(NREGS)
// PORTS
//   clk        in   1          system clock; all logic on rising edge
//   reset      in   1          asynchronous, active-high reset
//   scl        in   1          I2C clock from bus (asynchronous)
//   sda_in     in   1          I2C data sampled from bus (asynchronous)
//   sda_oe     out  1          1 = pull SDA low; 0 = release (external pull-up)
//   regs_flat  out  8*NREGS    register file contents, reg k at [8k+7:8k]
//   wr_pulse   out  1          one-cycle strobe when a register is written
//   wr_index   out  PTR_W      index of register written, valid with wr_pulse
//   busy       out  1          1 from START through STOP/abort
// BEHAVIOUR
//   - Reset (async): sda_oe=0, regs_flat=0, wr_pulse=0, wr_index=0, busy=0, ptr=0, state IDLE.
//   - scl/sda_in pass 2-FF synchronisers plus one history FF; edges decoded from sync'd values
//     (3-cycle detect latency). Bench keeps SCL high/low phases >= 8 clk.
//   - START: sda fall while scl high -> busy=1, bit counter=0, state ADDR (from any state; repeated START).
//   - STOP: sda rise while scl high -> sda_oe=0, busy=0, state IDLE (from any state). Pointer is kept.
//   - Bits shifted MSB-first on detected scl rise; sda_oe changes only on the cycle after a detected scl fall.
//   - States:
//     IDLE      wait for START.
//     ADDR      shift 8 bits; on 8th: addr[7:1]==DEV_ADDR -> ADDR_ACK, else IGNORE.
//     IGNORE    sda_oe=0 until START/STOP.
//     ADDR_ACK  drive 0 for the 9th clock; released after its scl fall; R/W=0 -> PTR, R/W=1 -> RDATA
//               (first read bit driven on that same scl fall).
//     PTR       shift 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored) -> PTR_ACK.
//     PTR_ACK   drive ACK -> WDATA.
//     WDATA     shift 8 bits; on 8th: regs[ptr]<=byte, wr_pulse=1 one cycle, wr_index=ptr,
//               ptr<=ptr+1 mod NREGS -> WDATA_ACK.
//     WDATA_ACK drive ACK -> WDATA.
//     RDATA     load regs[ptr] into shift reg at entry; drive sda_oe=~bit (MSB first) per scl fall;
//               after 8th bit release SDA, ptr<=ptr+1 mod NREGS -> RDATA_ACK.
//     RDATA_ACK sample master bit on scl rise: 0 (ACK) -> RDATA next byte; 1 (NACK) -> IGNORE until STOP/START.
//   - Never drives SDA in ADDR, PTR, WDATA, IGNORE, IDLE.
//   - Pointer wrap: write to reg NREGS-1 followed by another byte writes reg 0.
//   - Reset mid-transfer: immediate release of SDA and return to IDLE; registers cleared.
//   - START and STOP are detected only while scl high; sda change while scl low is data.
// TESTING
//   1 Write: S, 0xAA(0x55<<1|W), 0x01, 0x3C, P -> three ACKs (sda_oe=1 on 9th clocks), reg1=0x3C,
//     single wr_pulse with wr_index=1, busy 1->0 after STOP.
//   2 Read: preload reg2=0x5A; S,0xAA,0x02, Sr,0xAB, master NACK, P -> bytes on SDA = 0x5A, ptr=3 after.
//   3 Address miss: S, 0x90 (addr 0x48), 0x11, P -> sda_oe stays 0 throughout, no wr_pulse, regs unchanged.
//   4 Wrap/burst: S,0xAA,0x03,0x11,0x22,0x33,P -> reg3=0x11, reg0=0x22, reg1=0x33, three wr_pulses idx 3,0,1.
//   5 Burst read with ACK,ACK,NACK from ptr 3 -> bytes reg3, reg0, reg1; SDA released after NACK.
//   6 Reset asserted while driving ACK -> sda_oe=0 and regs 0 asynchronously; next clean write succeeds.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with auto-incrementing 8-bit register file
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter int         NREGS    = 4,
  parameter int         PTR_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scl,
  input  logic               sda_in,
  output logic               sda_oe,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               wr_pulse,
  output logic [PTR_W-1:0]   wr_index,
  output logic               busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    IGNORE,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  state_t           state;
  logic             scl_s1, scl_s2, scl_h;
  logic             sda_s1, sda_s2, sda_h;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]       shift;
  logic [7:0]       rx_byte;
  logic [7:0]       tx;
  logic [3:0]       bitcnt;
  logic             ack_on;
  logic             rw;
  logic             master_nack;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NREGS];

  // Pointer advance with wrap at the end of the register file
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREGS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Bus synchronisers plus one history stage; idle bus level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // Bus event decode; START/STOP only qualify while scl is steadily high
  always_comb begin
    scl_rise  = scl_s2 & ~scl_h;
    scl_fall  = ~scl_s2 & scl_h;
    start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    rx_byte   = {shift, sda_s2};
  end

  // Flattened view of the register file
  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_flat[8*k +: 8] = regs[k];
    end
  end

  // Protocol FSM: START/STOP override everything, otherwise per-state bit handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sda_oe      <= 1'b0;
      wr_pulse    <= 1'b0;
      wr_index    <= '0;
      busy        <= 1'b0;
      ptr         <= '0;
      shift       <= '0;
      tx          <= '0;
      bitcnt      <= '0;
      ack_on      <= 1'b0;
      rw          <= 1'b0;
      master_nack <= 1'b0;
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        busy   <= 1'b1;
        bitcnt <= '0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          IDLE, IGNORE: begin
            sda_oe <= 1'b0;
          end

          ADDR: begin
            sda_oe <= 1'b0;
            if (scl_rise) begin
              shift <= rx_byte[6:0];
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                rw     <= rx_byte[0];
                state  <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          // First fall (end of 8th bit) asserts ACK, second fall (end of 9th) releases it
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                bitcnt <= '0;
                if (rw) begin
                  state  <= RDATA;
                  sda_oe <= ~regs[ptr][7];
                  tx     <= {regs[ptr][6:0], 1'b0};
                end else begin
                  state  <= PTR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          PTR: begin
            sda_oe <= 1'b0;
            if (scl_rise) begin
              shift <= rx_byte[6:0];
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                ptr    <= rx_byte[PTR_W-1:0];
                state  <= PTR_ACK;
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                bitcnt <= '0;
                state  <= WDATA;
              end
            end
          end

          WDATA: begin
            sda_oe <= 1'b0;
            if (scl_rise) begin
              shift <= rx_byte[6:0];
              if (bitcnt == 4'd7) begin
                bitcnt    <= '0;
                regs[ptr] <= rx_byte;
                wr_pulse  <= 1'b1;
                wr_index  <= ptr;
                ptr       <= ptr_inc(ptr);
                state     <= WDATA_ACK;
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          // Each fall presents the next bit; the fall after the 8th bit releases the bus
          RDATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                bitcnt <= '0;
                ptr    <= ptr_inc(ptr);
                state  <= RDATA_ACK;
              end else begin
                sda_oe <= ~tx[7];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end

          // Master's ACK/NACK is sampled on the rise and acted on at the following fall
          RDATA_ACK: begin
            if (scl_rise) begin
              master_nack <= sda_s2;
            end else if (scl_fall) begin
              if (master_nack) begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end else begin
                sda_oe <= ~regs[ptr][7];
                tx     <= {regs[ptr][6:0], 1'b0};
                bitcnt <= '0;
                state  <= RDATA;
              end
            end
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - randomized bus-level bench for i2c_slave_regs
module tb_i2c_slave_regs;

  localparam int H     = 10;
  localparam int NREGS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_scl;
  logic        m_sda;
  logic        sda_bus;
  logic        sda_oe;
  logic [31:0] regs_flat;
  logic        wr_pulse;
  logic [1:0]  wr_index;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          oe_cnt = 0;
  logic [7:0]  mregs [NREGS];
  int          mptr = 0;
  int          exp_wr [$];
  int          wr_q [$];
  logic [7:0]  wbuf [8];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (m_scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  // Write-strobe and SDA-drive monitors, sampled on the inactive edge
  always @(negedge clk) begin
    if (!reset && wr_pulse) wr_q.push_back(int'(wr_index));
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clks(H);
    m_scl = 1'b1; wait_clks(H);
    m_sda = 1'b0; wait_clks(H);
    m_scl = 1'b0; wait_clks(H);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clks(H);
    m_scl = 1'b1; wait_clks(H);
    m_sda = 1'b1; wait_clks(H);
  endtask

  task automatic send_bits8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_clks(2); m_sda = b[i];
      wait_clks(H); m_scl = 1'b1;
      wait_clks(H); m_scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits8(b);
    wait_clks(2); m_sda = 1'b1;
    wait_clks(H); m_scl = 1'b1;
    wait_clks(H/2); ack = ~sda_bus;
    wait_clks(H/2); m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(H); m_scl = 1'b1;
      wait_clks(H/2); b[i] = sda_bus;
      wait_clks(H/2); m_scl = 1'b0;
    end
    wait_clks(2); m_sda = nack;
    wait_clks(H); m_scl = 1'b1;
    wait_clks(H); m_scl = 1'b0;
    wait_clks(2); m_sda = 1'b1;
  endtask

  task automatic check_regs();
    for (int k = 0; k < NREGS; k++) chk($sformatf("reg%0d", k), int'(regs_flat[8*k +: 8]), int'(mregs[k]));
  endtask

  task automatic check_writes();
    chk("wr_count", wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) chk("wr_index", wr_q[i], exp_wr[i]);
    wr_q.delete();
    exp_wr.delete();
  endtask

  task automatic write_txn(input logic [7:0] pb, input int n);
    logic ack;
    i2c_start();
    chk("busy_in", int'(busy), 1);
    send_byte(8'hAA, ack); chk("w_addr_ack", int'(ack), 1);
    send_byte(pb, ack);    chk("w_ptr_ack", int'(ack), 1);
    mptr = int'(pb) % NREGS;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack); chk("w_data_ack", int'(ack), 1);
      mregs[mptr] = wbuf[i];
      exp_wr.push_back(mptr);
      mptr = (mptr + 1) % NREGS;
    end
    chk("busy_before_stop", int'(busy), 1);
    i2c_stop();
    wait_clks(6);
    chk("busy_after_stop", int'(busy), 0);
    check_writes();
    check_regs();
  endtask

  task automatic read_txn(input logic set_ptr, input logic [7:0] pb, input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hAA, ack); chk("r_waddr_ack", int'(ack), 1);
      send_byte(pb, ack);    chk("r_ptr_ack", int'(ack), 1);
      mptr = int'(pb) % NREGS;
      i2c_start();
    end
    send_byte(8'hAB, ack); chk("r_addr_ack", int'(ack), 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      chk("rd_byte", int'(b), int'(mregs[mptr]));
      mptr = (mptr + 1) % NREGS;
    end
    wait_clks(4);
    chk("rd_release", int'(sda_oe), 0);
    i2c_stop();
    wait_clks(6);
    chk("rd_busy_after", int'(busy), 0);
    check_writes();
  endtask

  task automatic miss_txn(input logic [6:0] a);
    logic ack;
    oe_cnt = 0;
    i2c_start();
    send_byte({a, 1'b0}, ack); chk("miss_addr_nack", int'(ack), 0);
    send_byte(8'h11, ack);     chk("miss_data_nack", int'(ack), 0);
    i2c_stop();
    wait_clks(6);
    chk("miss_oe_cycles", oe_cnt, 0);
    check_writes();
    check_regs();
  endtask

  initial begin
    logic ack;
    int   kind, n;
    reset = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
    wait_clks(5);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_regs", int'(regs_flat), 0);
    chk("rst_wr_pulse", int'(wr_pulse), 0);
    chk("rst_wr_index", int'(wr_index), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    wait_clks(5);

    // Single write to reg1
    wbuf[0] = 8'h3C;
    write_txn(8'h01, 1);

    // Preload reg2, then read it back through a repeated START; pointer lands on 3
    wbuf[0] = 8'h5A;
    write_txn(8'h02, 1);
    read_txn(1'b1, 8'h02, 1);
    read_txn(1'b0, 8'h00, 1);

    // Address miss
    miss_txn(7'h48);

    // Wrapping burst write from reg3
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(8'h03, 3);

    // Wrapping burst read from reg3: ACK, ACK, NACK
    read_txn(1'b1, 8'h03, 3);

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        write_txn(8'($urandom), n);
      end else if (kind == 2) begin
        read_txn(1'($urandom), 8'($urandom), $urandom_range(1, 5));
      end else begin
        miss_txn(7'h55 ^ 7'($urandom_range(1, 127)));
      end
    end

    // Reset while the address ACK is being driven
    i2c_start();
    send_bits8(8'hAA);
    wait_clks(2); m_sda = 1'b1;
    wait_clks(H);
    chk("ack_before_reset", int'(sda_oe), 1);
    reset = 1'b1;
    #1;
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_regs", int'(regs_flat), 0);
    chk("reset_busy", int'(busy), 0);
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
    wr_q.delete();
    exp_wr.delete();
    wait_clks(3);
    reset = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clks(H);
    wbuf[0] = 8'hC3; wbuf[1] = 8'h7E;
    write_txn(8'h02, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
